// File: rtl/hardware_node_pkg.sv
// Shared heap-node definitions: word/node widths, tag codes, fetch FSM states.
package hardware_node_pkg;

  localparam int NODE_W = 63;
  localparam int WORD_W = 64;
  localparam int PTR_W  = 30;

  localparam logic [3:0] TAG_S   = 4'd0;
  localparam logic [3:0] TAG_K   = 4'd1;
  localparam logic [3:0] TAG_I   = 4'd2;
  localparam logic [3:0] TAG_APP = 4'd3;
  localparam logic [3:0] TAG_LIT = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/hardware_node_word_decode.sv
// Combinational 64-bit heap word -> 63-bit tagged node decode.
// Unknown tags (5..15) decode to an all-zero node and raise err.
module hardware_node_word_decode
  import hardware_node_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [NODE_W-1:0] node,
  output logic              err
);

  logic [3:0] tag;
  assign tag = word[63:60];

  // Tag-directed repack of the payload into the node layout
  always_comb begin
    node = '0;
    err  = 1'b0;
    case (tag)
      TAG_S, TAG_K, TAG_I: node = {tag[2:0], 60'b0};
      TAG_APP:             node = {3'b011, word[59:30], word[29:0]};
      TAG_LIT:             node = {3'b100, word[31:0], 28'b0};
      default:             err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/hardware_node_fetch_arb.sv
// Two-requester round-robin node fetch arbiter in front of the single-port heap.
// One fetch outstanding at a time: IDLE (grant) -> WAIT (memory latency) -> RESP (handshake).
// Optional feature macro: HASKI_TAG_CHECK_EN adds the rsp_err port flagging illegal heap tags.
module hardware_node_fetch_arb
  import hardware_node_pkg::*;
#(
  parameter int ADDR_W  = PTR_W,
  parameter int MEM_LAT = 1
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [NODE_W-1:0] rsp_node,
  input  logic              rsp_ready,
  output logic              busy
`ifdef HASKI_TAG_CHECK_EN
  ,
  output logic              rsp_err
`endif
);

  // WAIT lasts MEM_LAT cycles; the capture edge is MEM_LAT edges after the grant edge
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t              state, state_nxt;
  logic                rr_last;
  logic [2:0]          lat_cnt;
  logic                pick0, pick1, grant;
  logic [NODE_W-1:0]   dec_node;
  logic                dec_err;
  logic                err_q;

  // On a tie the requester that did not win last time goes first
  assign pick1 = req1_valid && (!req0_valid || !rr_last);
  assign pick0 = req0_valid && !pick1;
  assign grant = req0_ready || req1_ready;

  hardware_node_word_decode u_dec (
    .word (mem_rd_data),
    .node (dec_node),
    .err  (dec_err)
  );

  // State register
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  // Next-state: grant leaves IDLE, latency expiry leaves WAIT, handshake leaves RESP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = WAIT;
      WAIT:    if (lat_cnt == 3'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ready is held low while reset is asserted
  always_comb begin
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    req0_ready = (state == IDLE) && system1000_rstn && pick0;
    req1_ready = (state == IDLE) && system1000_rstn && pick1;
  end

  // Datapath: issue the read on grant, count latency, capture the decoded word
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      rr_last     <= 1'b1;
      lat_cnt     <= 3'd0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rsp_id      <= 1'b0;
      rsp_node    <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_rd_en <= grant;
      if (grant) begin
        mem_rd_addr <= req1_ready ? req1_addr : req0_addr;
        rr_last     <= req1_ready;
        rsp_id      <= req1_ready;
        lat_cnt     <= LAT_INIT;
      end
      if (state == WAIT) begin
        if (lat_cnt == 3'd0) begin
          rsp_node <= dec_node;
          err_q    <= dec_err;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end
    end
  end

`ifdef HASKI_TAG_CHECK_EN
  assign rsp_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
